// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified I/D memory port arbiter.
package mem_arb_pkg;

  localparam int          STRB_W    = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store, one transaction at a time,
// data-biased with bounded fetch starvation and a watchdog that aborts hung accesses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [STRB_W-1:0] d_wstrb,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              stall_i,
  output logic              stall_d,
  output logic              timeout_err
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [7:0] WD_LIM     = 8'(TIMEOUT_CYCLES - 1);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_done;
  logic              w_tmo;
  logic              w_busy;
  logic [3:0]        r_starve_cnt;
  logic [7:0]        r_wd_cnt;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [STRB_W-1:0] r_mem_wstrb;
  logic [31:0]       r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [31:0]       r_i_rdata;
  logic [31:0]       r_d_rdata;
  logic              r_i_ack;
  logic              r_d_ack;
  logic              r_timeout_err;

  assign w_busy = (r_state == BUSY_I) || (r_state == BUSY_D);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    w_done    = 1'b0;
    w_tmo     = 1'b0;
    case (r_state)
      IDLE: begin
        // Data wins a tie unless fetch has already lost STARVE_MAX times in a row.
        if (d_req && (!i_req || (r_starve_cnt != STARVE_LIM))) begin
          w_grant_d = 1'b1;
          w_next    = BUSY_D;
        end else if (i_req) begin
          w_grant_i = 1'b1;
          w_next    = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack) begin
          w_done = 1'b1;
          w_next = (r_state == BUSY_I) ? RESP_I : RESP_D;
        end else if (r_wd_cnt == WD_LIM) begin
          w_tmo  = 1'b1;
          w_next = (r_state == BUSY_I) ? RESP_I : RESP_D;
        end
      end
      RESP_I, RESP_D: w_next = IDLE;
      default:        w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_wstrb   <= '0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_i_rdata     <= '0;
      r_d_rdata     <= '0;
      r_i_ack       <= 1'b0;
      r_d_ack       <= 1'b0;
      r_timeout_err <= 1'b0;
      r_starve_cnt  <= '0;
      r_wd_cnt      <= '0;
    end else begin
      r_mem_req <= (w_next == BUSY_I) || (w_next == BUSY_D);
      r_i_ack   <= (w_next == RESP_I);
      r_d_ack   <= (w_next == RESP_D);

      if (w_grant_i) begin
        r_mem_addr   <= i_addr;
        r_mem_we     <= 1'b0;
        r_mem_wstrb  <= '0;
        r_mem_wdata  <= '0;
        r_starve_cnt <= '0;
      end
      if (w_grant_d) begin
        r_mem_addr  <= d_addr;
        r_mem_we    <= d_we;
        r_mem_wstrb <= d_wstrb;
        r_mem_wdata <= d_wdata;
        if (i_req && (r_starve_cnt != STARVE_LIM))
          r_starve_cnt <= r_starve_cnt + 4'd1;
      end

      if (w_busy) r_wd_cnt <= r_wd_cnt + 8'd1;
      else        r_wd_cnt <= '0;

      if (w_done) begin
        if (r_state == BUSY_I) r_i_rdata <= mem_rdata;
        else                   r_d_rdata <= mem_rdata;
      end
      // A hung fetch returns a NOP so the pipeline keeps moving after the abort.
      if (w_tmo) begin
        r_timeout_err <= 1'b1;
        if (r_state == BUSY_I) r_i_rdata <= NOP_INSTR;
        else                   r_d_rdata <= '0;
      end
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_wstrb   = r_mem_wstrb;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign i_rdata     = r_i_rdata;
  assign d_rdata     = r_d_rdata;
  assign i_ack       = r_i_ack;
  assign d_ack       = r_d_ack;
  assign timeout_err = r_timeout_err;
  assign stall_i     = i_req & ~r_i_ack;
  assign stall_d     = d_req & ~r_d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected memory transactions and acks are queued
// as requests are driven, and popped when the memory model / ack monitor sees them.
module tb_mem_port_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          cyc;
  } txn_t;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    int          cyc;
  } ack_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_wstrb = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        stall_i;
  logic        stall_d;
  logic        timeout_err;

  int   n_total = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   lat = 0;
  int   bcnt = 0;
  bit   use_ovr = 0;
  logic [31:0] rd_ovr = '0;
  txn_t txq[$];
  ack_t ackq[$];
  txn_t cur;

  mem_port_arbiter #(.STARVE_MAX(3), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_i(stall_i), .stall_d(stall_d), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic txn_t mk_txn(input logic [31:0] a, input logic we, input logic [3:0] st,
                                  input logic [31:0] wd, input int c);
    txn_t t;
    t.addr = a; t.we = we; t.wstrb = st; t.wdata = wd; t.cyc = c;
    return t;
  endfunction

  function automatic ack_t mk_ack(input logic port, input logic [31:0] rd, input int c);
    ack_t e;
    e.port = port; e.rdata = rd; e.cyc = c;
    return e;
  endfunction

  // Memory model: acks `lat` cycles after mem_req rises (lat<0 never acks).
  always @(negedge clk) begin
    mem_ack   = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    if (reset || !mem_req) begin
      bcnt = 0;
    end else begin
      if (bcnt == 0) begin
        if (txq.size() == 0) begin
          check("txn_unexp", 32'(txq.size()), 32'd1);
          cur = mk_txn(mem_addr, mem_we, mem_wstrb, mem_wdata, -1);
        end else begin
          cur = txq.pop_front();
          check("txn_addr", mem_addr, cur.addr);
          check("txn_we", 32'(mem_we), 32'(cur.we));
          check("txn_wstrb", 32'(mem_wstrb), 32'(cur.wstrb));
          check("txn_wdata", mem_wdata, cur.wdata);
          if (cur.cyc >= 0) check("txn_cyc", 32'(cyc), 32'(cur.cyc));
        end
      end
      if (bcnt == lat) begin
        if (bcnt > 0) begin
          check("hold_addr", mem_addr, cur.addr);
          check("hold_we", 32'(mem_we), 32'(cur.we));
          check("hold_wstrb", 32'(mem_wstrb), 32'(cur.wstrb));
          check("hold_wdata", mem_wdata, cur.wdata);
        end
        mem_ack   = 1'b1;
        mem_rdata = use_ovr ? rd_ovr : mdata(cur.addr);
      end
      bcnt++;
    end
  end

  task automatic ack_seen(input logic port, input logic [31:0] rd);
    ack_t e;
    if (ackq.size() == 0) begin
      check("ack_unexp", 32'(ackq.size()), 32'd1);
      return;
    end
    e = ackq.pop_front();
    check("ack_port", 32'(port), 32'(e.port));
    check("ack_rdata", rd, e.rdata);
    if (e.cyc >= 0) check("ack_cyc", 32'(cyc), 32'(e.cyc));
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (i_ack) ack_seen(1'b0, i_rdata);
      if (d_ack) ack_seen(1'b1, d_rdata);
    end
  end

  task automatic do_fetch(input logic [31:0] a);
    bit got = 0;
    i_addr = a;
    i_req  = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (i_ack) begin got = 1; break; end
      check("stall_i_wait", 32'(stall_i), 32'd1);
    end
    check("i_ack_seen", 32'(got), 32'd1);
    check("stall_i_ack", 32'(stall_i), 32'd0);
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic do_data(input logic [31:0] a, input logic we, input logic [3:0] st,
                         input logic [31:0] wd);
    bit got = 0;
    d_addr = a; d_we = we; d_wstrb = st; d_wdata = wd;
    d_req  = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (d_ack) begin got = 1; break; end
      check("stall_d_wait", 32'(stall_d), 32'd1);
    end
    check("d_ack_seen", 32'(got), 32'd1);
    check("stall_d_ack", 32'(stall_d), 32'd0);
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0; d_wstrb = '0;
  endtask

  task automatic sync(output int t);
    @(posedge clk); #1;
    t = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int t0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_i_ack", 32'(i_ack), 32'd0);
    check("rst_d_ack", 32'(d_ack), 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_tmo", 32'(timeout_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single fetch, zero-latency memory.
    lat = 0; use_ovr = 1; rd_ovr = 32'h0050_0093;
    sync(t0);
    txq.push_back(mk_txn(32'h100, 0, 4'h0, 32'h0, t0 + 1));
    ackq.push_back(mk_ack(0, 32'h0050_0093, t0 + 2));
    do_fetch(32'h100);
    use_ovr = 0;
    repeat (2) @(posedge clk);

    // Simultaneous fetch and load: data first, fetch after.
    lat = 2;
    sync(t0);
    txq.push_back(mk_txn(32'h2000, 0, 4'h0, 32'h0, t0 + 1));
    txq.push_back(mk_txn(32'h104, 0, 4'h0, 32'h0, t0 + 6));
    ackq.push_back(mk_ack(1, mdata(32'h2000), t0 + 4));
    ackq.push_back(mk_ack(0, mdata(32'h104), t0 + 9));
    fork
      do_data(32'h2000, 1'b0, 4'h0, 32'h0);
      do_fetch(32'h104);
    join
    repeat (2) @(posedge clk);

    // Back-to-back loads against a held fetch: three data wins, then fetch.
    lat = 1;
    sync(t0);
    for (int k = 0; k < 3; k++) begin
      txq.push_back(mk_txn(32'h5000 + 32'(4 * k), 0, 4'h0, 32'h0, t0 + 1 + 4 * k));
      ackq.push_back(mk_ack(1, mdata(32'h5000 + 32'(4 * k)), t0 + 3 + 4 * k));
    end
    txq.push_back(mk_txn(32'h108, 0, 4'h0, 32'h0, t0 + 13));
    ackq.push_back(mk_ack(0, mdata(32'h108), t0 + 15));
    txq.push_back(mk_txn(32'h500C, 0, 4'h0, 32'h0, t0 + 17));
    ackq.push_back(mk_ack(1, mdata(32'h500C), t0 + 19));
    fork
      begin
        for (int k = 0; k < 4; k++) do_data(32'h5000 + 32'(4 * k), 1'b0, 4'h0, 32'h0);
      end
      do_fetch(32'h108);
    join
    repeat (2) @(posedge clk);

    // Byte store held across a 3-cycle memory.
    lat = 3;
    sync(t0);
    txq.push_back(mk_txn(32'h3000, 1, 4'b0100, 32'hAABB_CCDD, t0 + 1));
    ackq.push_back(mk_ack(1, mdata(32'h3000), t0 + 5));
    do_data(32'h3000, 1'b1, 4'b0100, 32'hAABB_CCDD);
    repeat (2) @(posedge clk);

    // mem_ack exactly on the watchdog's last cycle completes normally.
    lat = 7;
    sync(t0);
    txq.push_back(mk_txn(32'h300, 0, 4'h0, 32'h0, t0 + 1));
    ackq.push_back(mk_ack(0, mdata(32'h300), t0 + 9));
    do_fetch(32'h300);
    check("tmo_edge_clear", 32'(timeout_err), 32'd0);
    repeat (2) @(posedge clk);

    // Fetch that never completes: NOP returned, sticky error.
    lat = -1;
    sync(t0);
    txq.push_back(mk_txn(32'h200, 0, 4'h0, 32'h0, t0 + 1));
    ackq.push_back(mk_ack(0, 32'h0000_0013, t0 + 9));
    do_fetch(32'h200);
    check("tmo_set_i", 32'(timeout_err), 32'd1);

    // Load that never completes returns zero.
    sync(t0);
    txq.push_back(mk_txn(32'h6000, 0, 4'h0, 32'h0, t0 + 1));
    ackq.push_back(mk_ack(1, 32'h0, t0 + 9));
    do_data(32'h6000, 1'b0, 4'h0, 32'h0);

    lat = 0;
    sync(t0);
    txq.push_back(mk_txn(32'h204, 0, 4'h0, 32'h0, t0 + 1));
    ackq.push_back(mk_ack(0, mdata(32'h204), t0 + 2));
    do_fetch(32'h204);
    check("tmo_sticky", 32'(timeout_err), 32'd1);
    repeat (2) @(posedge clk);

    // Reset in the middle of a load; the held request is re-arbitrated afterwards.
    lat = -1;
    sync(t0);
    txq.push_back(mk_txn(32'h4000, 0, 4'h0, 32'h0, t0 + 1));
    fork
      do_data(32'h4000, 1'b0, 4'h0, 32'h0);
      begin
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("rst_mid_mem_req", 32'(mem_req), 32'd0);
        check("rst_mid_d_ack", 32'(d_ack), 32'd0);
        check("rst_mid_tmo", 32'(timeout_err), 32'd0);
        txq.push_back(mk_txn(32'h4000, 0, 4'h0, 32'h0, -1));
        ackq.push_back(mk_ack(1, mdata(32'h4000), -1));
        @(posedge clk);
        #3 lat = 1;
        reset = 1'b0;
      end
    join
    check("post_rst_tmo", 32'(timeout_err), 32'd0);

    repeat (4) @(posedge clk);
    check("txq_left", 32'(txq.size()), 32'd0);
    check("ackq_left", 32'(ackq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
